un_striping_sched: RTL and testbench

Two-lane reassembly scheduler for the unstriping path. It accepts 32-bit words from `lane_0` and `lane_1` (each qualified by its own valid) and buffers each lane in a small FIFO to absorb inter-lane skew. It then emits a single stream on `clk_2f` in strict lane order 0,1,0,1…. It sits between the lane deserializers and the downstream consumer, and owns lane sequencing and skew/overflow reporting.

---
 rtl/un_striping_sched.sv | 181 ++++++++++++++++++
 tb/tb_un_striping_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/un_striping_sched.sv
`default_nettype none
// ============================================================================
// Module   : un_striping_sched
// Purpose  : Two-lane unstriping scheduler. Per-lane skew FIFOs feed a
//            strict lane 0,1,0,1 reassembly stream with overflow reporting.
// Options  : UNSTRIPE_TIMEOUT_EN enables stall timeout with FIFO flush/resync.
// Revision : 1.0 - initial release
// ============================================================================
module un_striping_sched #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      lane_0,
  input  logic                   valid_0,
  input  logic [DATA_W-1:0]      lane_1,
  input  logic                   valid_1,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic                   next_lane,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fill_0,
  output logic [$clog2(DEPTH):0] fill_1,
  output logic                   overflow_err,
  output logic                   resync
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_0 = 2'd1,
    WAIT_1 = 2'd2
  } state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("un_striping_sched: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
  end

  state_t              state_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                valid_out_q;
  logic                overflow_q;

  logic [DATA_W-1:0]   w_lane  [2];
  logic [DATA_W-1:0]   w_rdata [2];
  logic [AW:0]         w_cnt   [2];
  logic [1:0]          w_valid;
  logic [1:0]          w_empty;
  logic [1:0]          w_pop;
  logic [1:0]          w_drop;
  logic                w_flush;

  assign w_lane[0] = lane_0;
  assign w_lane[1] = lane_1;
  assign w_valid   = {valid_1, valid_0};

  // Only the lane selected by the current state may be popped.
  assign w_pop[0] = (state_q == IDLE || state_q == WAIT_0) && !w_empty[0] && !w_flush;
  assign w_pop[1] = (state_q == WAIT_1) && !w_empty[1] && !w_flush;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [AW:0]       cnt_q;
    logic              full;
    logic              push;

    // A full FIFO still accepts a push when it is popped on the same edge.
    assign full      = (cnt_q == (AW + 1)'(DEPTH));
    assign push      = w_valid[l] && (!full || w_pop[l]) && !w_flush;
    assign w_drop[l] = w_valid[l] && full && !w_pop[l] && !w_flush;
    assign w_empty[l] = (cnt_q == '0);
    assign w_rdata[l] = mem_q[rd_q];
    assign w_cnt[l]   = cnt_q;

    always_ff @(posedge clk_2f) begin
      if (push) mem_q[wr_q] <= w_lane[l];
    end

    always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else if (w_flush) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push)     wr_q <= wr_q + 1'b1;
        if (w_pop[l]) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, w_pop[l]};
      end
    end
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      overflow_q  <= overflow_q | (|w_drop);
      if (w_flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (w_pop[0]) begin
              data_out_q  <= w_rdata[0];
              valid_out_q <= 1'b1;
              state_q     <= WAIT_1;
            end
          end
          // A pair is never split: WAIT_1 only ever advances by popping lane 1.
          WAIT_1: begin
            if (w_pop[1]) begin
              data_out_q  <= w_rdata[1];
              valid_out_q <= 1'b1;
              state_q     <= WAIT_0;
            end
          end
          WAIT_0: begin
            if (w_pop[0]) begin
              data_out_q  <= w_rdata[0];
              valid_out_q <= 1'b1;
              state_q     <= WAIT_1;
            end else if (w_empty[1] && !valid_0 && !valid_1) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef UNSTRIPE_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_q;
  logic          resync_q;
  logic          w_stalled;

  // Stalled: the lane we wait on is dry while the other lane has data queued.
  assign w_stalled = (state_q == WAIT_1 && w_empty[1] && !w_empty[0]) ||
                     (state_q == WAIT_0 && w_empty[0] && !w_empty[1]);
  assign w_flush   = (stall_q == SW'(TIMEOUT));
  assign resync    = resync_q;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      resync_q <= 1'b0;
    end else begin
      resync_q <= w_flush;
      if (w_flush || !w_stalled) stall_q <= '0;
      else                       stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign w_flush = 1'b0;
  assign resync  = 1'b0;
`endif

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign next_lane    = (state_q == WAIT_1);
  assign busy         = (state_q != IDLE);
  assign fill_0       = w_cnt[0];
  assign fill_1       = w_cnt[1];
  assign overflow_err = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_un_striping_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_un_striping_sched
// Purpose  : Self-checking bench; lane-order model feeds an expected-output
//            queue that the output monitor consumes. Timeout case runs only
//            when UNSTRIPE_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_un_striping_sched;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk_2f;
  logic              reset;
  logic [DATA_W-1:0] lane_0, lane_1;
  logic              valid_0, valid_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out, next_lane, busy, overflow_err, resync;
  logic [2:0]        fill_0, fill_1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m0[$], m1[$], sb[$];
  bit          turn;

  un_striping_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(8)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .lane_0(lane_0), .valid_0(valid_0),
    .lane_1(lane_1), .valid_1(valid_1),
    .data_out(data_out), .valid_out(valid_out),
    .next_lane(next_lane), .busy(busy),
    .fill_0(fill_0), .fill_1(fill_1),
    .overflow_err(overflow_err), .resync(resync)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane-order reference: words leave strictly alternating 0,1,0,1.
  task automatic model_push(input bit l, input logic [31:0] d);
    if (l) m1.push_back(d);
    else   m0.push_back(d);
    for (int i = 0; i < 16; i++) begin
      if (!turn && m0.size() != 0) begin
        sb.push_back(m0.pop_front());
        turn = 1'b1;
      end else if (turn && m1.size() != 0) begin
        sb.push_back(m1.pop_front());
        turn = 1'b0;
      end
    end
  endtask

  task automatic model_clear();
    m0.delete(); m1.delete(); sb.delete();
    turn = 1'b0;
  endtask

  task automatic drive(input bit v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1);
    @(negedge clk_2f);
    valid_0 = v0; lane_0 = d0;
    valid_1 = v1; lane_1 = d1;
    if (v0) model_push(1'b0, d0);
    if (v1) model_push(1'b1, d1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  always @(negedge clk_2f) begin : mon
    logic [31:0] e;
    if (reset && valid_out) begin
      if (sb.size() == 0) check("spurious_valid", valid_out, 1'b0);
      else begin
        e = sb.pop_front();
        check("stream", data_out, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
    model_clear();
    repeat (2) @(negedge clk_2f);
    check("rst_outs", {data_out, valid_out, next_lane, busy, overflow_err, resync}, '0);
    check("rst_fill", {fill_0, fill_1}, '0);
    reset = 1'b1;

    // Basic order
    drive(1'b1, 32'hFFFFFFFF, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'hEEEEEEEE);
    check("basic_fill0", fill_0, 1);
    check("basic_v_e1", valid_out, 0);
    drive(1'b0, '0, 1'b0, '0);
    check("basic_v_e2", valid_out, 1);
    check("basic_lane_e2", next_lane, 1);
    drive(1'b0, '0, 1'b0, '0);
    check("basic_v_e3", valid_out, 1);
    check("basic_lane_e3", next_lane, 0);
    drive(1'b0, '0, 1'b0, '0);
    check("basic_idle", busy, 0);
    check("basic_v_e4", valid_out, 0);

    // Lane-1 lead
    drive(1'b0, '0, 1'b1, 32'hCCCCCCCC);
    idle(1);
    check("lead_fill1_e1", fill_1, 1);
    check("lead_v_e1", valid_out, 0);
    idle(1);
    check("lead_fill1_e2", fill_1, 1);
    drive(1'b1, 32'hDDDDDDDD, 1'b0, '0);
    check("lead_v_e3", valid_out, 0);
    idle(1);
    check("lead_v_e4", valid_out, 0);
    check("lead_fill1_e4", fill_1, 1);
    idle(1);
    check("lead_v_e5", valid_out, 1);
    check("lead_fill1_e5", fill_1, 1);
    idle(1);
    check("lead_v_e6", valid_out, 1);
    check("lead_fill1_e6", fill_1, 0);
    idle(1);

    // Gap and restart, simultaneous pushes
    drive(1'b1, 32'h1, 1'b1, 32'h2);
    idle(1);
    check("gap_fill", {fill_0, fill_1}, {3'd1, 3'd1});
    idle(3);
    check("gap_busy_a", busy, 0);
    idle(1);
    check("gap_busy_b", busy, 0);
    drive(1'b1, 32'h3, 1'b1, 32'h4);
    idle(4);
    check("gap_done", busy, 0);

    // Overflow: DEPTH+1 pushes fill to DEPTH, the next one is dropped
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 32'h10 + i, 1'b0, '0);
    @(negedge clk_2f);
    check("ovf_fill_full", fill_0, DEPTH);
    check("ovf_not_yet", overflow_err, 0);
    valid_0 = 1'b1; lane_0 = 32'h15;
    drive(1'b0, '0, 1'b0, '0);
    check("ovf_set", overflow_err, 1);
    check("ovf_fill_held", fill_0, DEPTH);
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, 1'b1, 32'h20 + i);
    idle(8);
    check("ovf_sticky", overflow_err, 1);
    check("ovf_drained", {fill_0, fill_1, busy}, '0);

    // Async reset in WAIT_1 with fill_0=2
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h30 + i, 1'b0, '0);
    idle(1);
    check("ar_pre_fill0", fill_0, 2);
    check("ar_pre_lane", next_lane, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_outs", {data_out, valid_out, next_lane, busy, overflow_err, resync}, '0);
    check("ar_fill", {fill_0, fill_1}, '0);
    model_clear();
    @(negedge clk_2f);
    reset = 1'b1;
    drive(1'b0, '0, 1'b1, 32'h40);
    idle(3);
    check("ar_lane1_only_v", valid_out, 0);
    check("ar_lane1_fill", fill_1, 1);
    drive(1'b1, 32'h41, 1'b0, '0);
    idle(5);
    check("ar_done", busy, 0);

`ifdef UNSTRIPE_TIMEOUT_EN
    begin : t_timeout
      int k;
      bit seen;
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h50 + i, 1'b0, '0);
      k = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        drive(1'b0, '0, 1'b0, '0);
        k++;
        if (resync) seen = 1'b1;
      end
      check("to_seen", seen, 1);
      check("to_cycles", k, 8);
      check("to_flushed", {fill_0, fill_1, busy}, '0);
      model_clear();
      idle(1);
      check("to_pulse", resync, 0);
    end
`endif

    idle(2);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
